// File: rtl/control_unit_mc_if.sv
// Control-unit bus: IR/flag/handshake inputs and datapath strobes.
// master = control unit, slave = datapath side.
interface control_unit_mc_if #(
    parameter int OPCODE_W = 5,
    parameter int FLAG_W   = 4,
    parameter int SEL_W    = 3
);
    logic [OPCODE_W-1:0] OPCODE;
    logic [FLAG_W-1:0]   FLAGS;
    logic                STALL;
    logic                MEM_ACK;
    logic                LOAD_REG;
    logic [SEL_W-1:0]    LOAD_SELECT;
    logic                INC_PC;
    logic                LOAD_PC;
    logic                RD_EN;
    logic                WR_EN;
    logic                MODE;
    logic                PUSH;
    logic                POP;
    logic                HALTED;
    logic                ERR;
    logic [2:0]          STATE;

    modport master (
        input  OPCODE, FLAGS, STALL, MEM_ACK,
        output LOAD_REG, LOAD_SELECT, INC_PC, LOAD_PC,
        output RD_EN, WR_EN, MODE, PUSH, POP,
        output HALTED, ERR, STATE
    );

    modport slave (
        output OPCODE, FLAGS, STALL, MEM_ACK,
        input  LOAD_REG, LOAD_SELECT, INC_PC, LOAD_PC,
        input  RD_EN, WR_EN, MODE, PUSH, POP,
        input  HALTED, ERR, STATE
    );
endinterface

// File: rtl/control_unit_mc.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/mem/halt.
// Optional memory timeout abort: define CU_MEM_TIMEOUT_EN.
package control_unit_mc_pkg;
    localparam logic [4:0] OP_NOT  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_XOR  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_INC  = 5'd6;
    localparam logic [4:0] OP_DEC  = 5'd7;
    localparam logic [4:0] OP_MUL  = 5'd8;
    localparam logic [4:0] OP_DIV  = 5'd9;
    localparam logic [4:0] OP_JMP  = 5'd10;
    localparam logic [4:0] OP_CALL = 5'd11;
    localparam logic [4:0] OP_RET  = 5'd12;
    localparam logic [4:0] OP_BEQ  = 5'd13;
    localparam logic [4:0] OP_BNE  = 5'd14;
    localparam logic [4:0] OP_LD   = 5'd15;
    localparam logic [4:0] OP_ST   = 5'd16;
    localparam logic [4:0] OP_HALT = 5'd17;

    localparam logic [2:0] LOAD_IR    = 3'd1;
    localparam logic [2:0] LOAD_REG_A = 3'd2;
    localparam logic [2:0] LOAD_REG_B = 3'd3;
    localparam logic [2:0] LOAD_REG_C = 3'd4;
    localparam logic [2:0] LOAD_PC    = 3'd5;
endpackage

module control_unit_mc
    import control_unit_mc_pkg::*;
#(
    parameter int OPCODE_W      = 5,
    parameter int FLAG_W        = 4,
    parameter int SEL_W         = 3,
    parameter int MULDIV_CYCLES = 4,
    parameter int MEM_TIMEOUT   = 15
) (
    input logic              CLK,
    input logic              EN,
    control_unit_mc_if.master bus
);
    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_LA, C_LB, C_AR, C_MD, C_JMP, C_CALL, C_RET,
        C_BEQ, C_BNE, C_LD, C_ST, C_HLT, C_BAD
    } cls_t;

    localparam int CW = $clog2(MULDIV_CYCLES + 1);

    function automatic cls_t classify(input logic [OPCODE_W-1:0] op);
        case (op)
            OPCODE_W'(OP_NOT): return C_LA;
            OPCODE_W'(OP_AND),
            OPCODE_W'(OP_OR),
            OPCODE_W'(OP_XOR): return C_LB;
            OPCODE_W'(OP_ADD),
            OPCODE_W'(OP_SUB),
            OPCODE_W'(OP_INC),
            OPCODE_W'(OP_DEC): return C_AR;
            OPCODE_W'(OP_MUL),
            OPCODE_W'(OP_DIV): return C_MD;
            OPCODE_W'(OP_JMP): return C_JMP;
            OPCODE_W'(OP_CALL): return C_CALL;
            OPCODE_W'(OP_RET): return C_RET;
            OPCODE_W'(OP_BEQ): return C_BEQ;
            OPCODE_W'(OP_BNE): return C_BNE;
            OPCODE_W'(OP_LD): return C_LD;
            OPCODE_W'(OP_ST): return C_ST;
            OPCODE_W'(OP_HALT): return C_HLT;
            default: return C_BAD;
        endcase
    endfunction

    function automatic logic [SEL_W-1:0] alu_sel(input cls_t c);
        case (c)
            C_LB:    return SEL_W'(LOAD_REG_B);
            C_AR:    return SEL_W'(LOAD_REG_C);
            default: return SEL_W'(LOAD_REG_A);
        endcase
    endfunction

    state_t              st_q, st_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    cls_t                cd, cq;
    logic                ld, inc, ldpc, rd, wr;
    logic                mode, push, pop, err;
    logic [SEL_W-1:0]    sel;
    logic                unused_flags;

`ifdef CU_MEM_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] wcnt_q, wcnt_d;
`else
    localparam int unused_timeout = MEM_TIMEOUT;
`endif

    assign cd = classify(bus.OPCODE);
    assign cq = classify(op_q);
    assign unused_flags = ^bus.FLAGS[FLAG_W-1:1];

    // State, latched opcode and counters; reset clears all.
    always_ff @(posedge CLK or negedge EN) begin
        if (!EN) begin
            st_q  <= S_RESET;
            op_q  <= '0;
            cnt_q <= '0;
`ifdef CU_MEM_TIMEOUT_EN
            wcnt_q <= '0;
`endif
        end else begin
            st_q  <= st_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
`ifdef CU_MEM_TIMEOUT_EN
            wcnt_q <= wcnt_d;
`endif
        end
    end

    // Next-state and strobe decode; STALL freezes the core states.
    always_comb begin
        st_d  = st_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        ld    = 1'b0;
        sel   = '0;
        inc   = 1'b0;
        ldpc  = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        mode  = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        err   = 1'b0;
`ifdef CU_MEM_TIMEOUT_EN
        wcnt_d = wcnt_q;
`endif
        unique case (st_q)
            S_RESET: st_d = S_FETCH;
            S_FETCH: begin
                rd = 1'b1;
                if (bus.MEM_ACK) begin
                    ld   = 1'b1;
                    sel  = SEL_W'(LOAD_IR);
                    inc  = 1'b1;
                    st_d = S_DECODE;
                end
`ifdef CU_MEM_TIMEOUT_EN
                else if (wcnt_q == TW'(MEM_TIMEOUT)) begin
                    rd     = 1'b0;
                    err    = 1'b1;
                    wcnt_d = '0;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
`endif
            end
            S_DECODE: begin
                mode = (cd == C_LA) || (cd == C_LB);
                if (!bus.STALL) begin
                    op_d = bus.OPCODE;
                    st_d = S_FETCH;
                    case (cd)
                        C_LA, C_LB, C_AR, C_MD: begin
                            ld   = 1'b1;
                            sel  = alu_sel(cd);
                            st_d = S_EXECUTE;
                        end
                        C_JMP, C_CALL, C_RET: begin
                            ldpc = 1'b1;
                            sel  = SEL_W'(LOAD_PC);
                            push = (cd == C_CALL);
                            pop  = (cd == C_RET);
                        end
                        C_BEQ, C_BNE: begin
                            if (bus.FLAGS[0] == (cd == C_BEQ)) begin
                                ldpc = 1'b1;
                                sel  = SEL_W'(LOAD_PC);
                            end
                        end
                        C_LD, C_ST: st_d = S_MEM;
                        C_HLT:      st_d = S_HALT;
                        default:    st_d = S_FETCH;
                    endcase
                end
            end
            S_EXECUTE: begin
                mode = (cq == C_LA) || (cq == C_LB);
                if (!bus.STALL) begin
                    sel = alu_sel(cq);
                    if (cq != C_MD) begin
                        ld   = 1'b1;
                        st_d = S_FETCH;
                    end else if (cnt_q == CW'(MULDIV_CYCLES - 1)) begin
                        ld    = 1'b1;
                        cnt_d = '0;
                        st_d  = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_MEM: begin
                rd = (cq == C_LD);
                wr = (cq == C_ST);
                if (!bus.STALL) begin
                    if (bus.MEM_ACK) begin
                        if (cq == C_LD) begin
                            ld  = 1'b1;
                            sel = SEL_W'(LOAD_REG_A);
                        end
                        st_d = S_FETCH;
                    end
`ifdef CU_MEM_TIMEOUT_EN
                    else if (wcnt_q == TW'(MEM_TIMEOUT)) begin
                        rd   = 1'b0;
                        wr   = 1'b0;
                        err  = 1'b1;
                        st_d = S_FETCH;
                    end else begin
                        wcnt_d = wcnt_q + TW'(1);
                    end
`endif
                end
            end
            S_HALT:  st_d = S_HALT;
            default: st_d = S_RESET;
        endcase
`ifdef CU_MEM_TIMEOUT_EN
        if (st_d != st_q) wcnt_d = '0;
`endif
    end

    assign bus.LOAD_REG    = ld;
    assign bus.LOAD_SELECT = sel;
    assign bus.INC_PC      = inc;
    assign bus.LOAD_PC     = ldpc;
    assign bus.RD_EN       = rd;
    assign bus.WR_EN       = wr;
    assign bus.MODE        = mode;
    assign bus.PUSH        = push;
    assign bus.POP         = pop;
    assign bus.HALTED      = (st_q == S_HALT);
    assign bus.ERR         = err;
    assign bus.STATE       = st_q;
endmodule
